// File: rtl/mux_scan_sequencer_pkg.sv
// Shared types and constants for the mux scan sequencer.
// Pure declarations; no timing or flow control of its own.
package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Reload value for the dwell counter; a sample is taken when it reaches zero.
  function automatic logic [CNT_W-1:0] dwell_load(input int dwell);
    return CNT_W'(dwell - 1);
  endfunction

endpackage

// File: rtl/mux_scan_next_ch.sv
// Finds the lowest enabled channel strictly above cur (or the lowest overall when first=1).
// Combinational, zero latency; no flow control.
module mux_scan_next_ch
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] en,
  input  logic [SEL_W-1:0]  cur,
  input  logic              first,
  output logic [SEL_W-1:0]  nxt,
  output logic              found
);

  // Descending sweep so the last hit written is the lowest qualifying index.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (en[i] && (first || (i > int'(cur)))) begin
        nxt   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Walks the mux select over enabled channels, samples after each dwell, emits a 4-bit frame.
// Frame valid K*DWELL edges after start; frame/valid held in HOLD until frame_ready.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cont,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [SEL_W-1:0]  sel,
  input  logic              mux_out,
  output logic              busy,
  output logic [NUM_CH-1:0] frame,
  output logic              frame_valid,
  input  logic              frame_ready
);

  localparam logic [CNT_W-1:0] DWELL_LD = dwell_load(DWELL);

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [NUM_CH-1:0]   en_q;
  logic [NUM_CH-1:0]   en_d;
  logic [NUM_CH-1:0]   buf_q;
  logic [NUM_CH-1:0]   buf_d;
  logic [SEL_W-1:0]    sel_d;
  logic [NUM_CH-1:0]   frame_d;
  logic                frame_valid_d;

  logic [SEL_W-1:0]    first_idx;
  logic                first_found;
  logic [SEL_W-1:0]    next_idx;
  logic                next_found;
  logic [NUM_CH-1:0]   merged;
  logic                dwell_done;
  logic                launch;

  // First channel is looked up in the live ch_en: it is only consumed at a launch edge.
  mux_scan_next_ch u_first (
    .en    (ch_en),
    .cur   ('0),
    .first (1'b1),
    .nxt   (first_idx),
    .found (first_found)
  );

  mux_scan_next_ch u_next (
    .en    (en_q),
    .cur   (sel),
    .first (1'b0),
    .nxt   (next_idx),
    .found (next_found)
  );

  assign dwell_done = (cnt_q == '0);

  always_comb begin
    merged      = buf_q;
    merged[sel] = mux_out;
  end

  // A new scan starts from IDLE on start, or back-to-back from HOLD in continuous mode.
  always_comb begin
    launch = 1'b0;
    case (state_q)
      IDLE:    launch = start && first_found;
      HOLD:    launch = frame_ready && cont && first_found;
      default: launch = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (launch) state_d = SETTLE;
      end
      SETTLE: begin
        if (dwell_done && !next_found) state_d = HOLD;
      end
      HOLD: begin
        if (frame_ready) state_d = launch ? SETTLE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != IDLE);
    sel_d         = sel;
    cnt_d         = cnt_q;
    en_d          = en_q;
    buf_d         = buf_q;
    frame_d       = frame;
    frame_valid_d = frame_valid;
    case (state_q)
      SETTLE: begin
        if (!dwell_done) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          buf_d = merged;
          if (next_found) begin
            sel_d = next_idx;
            cnt_d = DWELL_LD;
          end else begin
            frame_d       = merged;
            frame_valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (frame_ready) begin
          frame_valid_d = 1'b0;
          sel_d         = '0;
        end
      end
      default: ;
    endcase
    // A launch overrides the HOLD return-to-zero select in the same edge.
    if (launch) begin
      en_d  = ch_en;
      sel_d = first_idx;
      cnt_d = DWELL_LD;
      buf_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel         <= '0;
      cnt_q       <= '0;
      en_q        <= '0;
      buf_q       <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
    end else begin
      sel         <= sel_d;
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      buf_q       <= buf_d;
      frame       <= frame_d;
      frame_valid <= frame_valid_d;
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer; a 4:1 mux model feeds mux_out from sel.
// Inputs change 1ns after the rising edge and outputs are checked at the same point.
module tb_mux_scan_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       cont;
  logic [3:0] ch_en;
  logic [1:0] sel;
  logic       mux_out;
  logic       busy;
  logic [3:0] frame;
  logic       frame_valid;
  logic       frame_ready;
  logic [3:0] in_vec;

  int tests;
  int failed;

  mux_scan_sequencer #(.DWELL(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cont        (cont),
    .ch_en       (ch_en),
    .sel         (sel),
    .mux_out     (mux_out),
    .busy        (busy),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready)
  );

  assign mux_out = in_vec[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests       = 0;
    failed      = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    cont        = 1'b0;
    ch_en       = 4'h0;
    frame_ready = 1'b0;
    in_vec      = 4'b1010;

    #12;
    chk("rst_sel",   32'(sel),         32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_frame", 32'(frame),       32'd0);
    chk("rst_valid", 32'(frame_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: full scan of all four channels
    ch_en = 4'b1111;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_e0_sel",   32'(sel),         32'd0);
    chk("t1_e0_busy",  32'(busy),        32'd1);
    chk("t1_e0_valid", 32'(frame_valid), 32'd0);
    for (int k = 1; k < 4; k++) begin
      repeat (3) tick();
      chk("t1_sel_hold", 32'(sel), 32'(k - 1));
      tick();
      chk("t1_sel_step", 32'(sel), 32'(k));
    end
    repeat (3) tick();
    chk("t1_valid_early", 32'(frame_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(frame_valid), 32'd1);
    chk("t1_frame", 32'(frame),       32'hA);
    chk("t1_sel3",  32'(sel),         32'd3);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("t1_hs_valid", 32'(frame_valid), 32'd0);
    chk("t1_hs_busy",  32'(busy),        32'd0);
    chk("t1_hs_sel",   32'(sel),         32'd0);
    chk("t1_hs_frame", 32'(frame),       32'hA);

    // 2: sparse enables; ch_en changes mid-scan must not matter
    ch_en = 4'b0101;
    start = 1'b1;
    tick();
    start = 1'b0;
    ch_en = 4'b0000;
    chk("t2a_sel0", 32'(sel), 32'd0);
    repeat (4) tick();
    chk("t2a_sel2", 32'(sel), 32'd2);
    repeat (3) tick();
    chk("t2a_valid_early", 32'(frame_valid), 32'd0);
    tick();
    chk("t2a_valid", 32'(frame_valid), 32'd1);
    chk("t2a_frame", 32'(frame),       32'h0);
    chk("t2a_sel",   32'(sel),         32'd2);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("t2a_hs_busy", 32'(busy), 32'd0);

    ch_en = 4'b1010;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2b_sel1", 32'(sel), 32'd1);
    repeat (4) tick();
    chk("t2b_sel3", 32'(sel), 32'd3);
    repeat (4) tick();
    chk("t2b_valid", 32'(frame_valid), 32'd1);
    chk("t2b_frame", 32'(frame),       32'hA);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("t2b_hs_valid", 32'(frame_valid), 32'd0);

    // 3: backpressure with start pulses during HOLD
    ch_en  = 4'b1111;
    in_vec = 4'b0011;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    chk("t3_valid", 32'(frame_valid), 32'd1);
    chk("t3_frame", 32'(frame),       32'h3);
    for (int c = 0; c < 10; c++) begin
      start = (c % 2 == 0);
      tick();
      chk("t3_bp_valid", 32'(frame_valid), 32'd1);
      chk("t3_bp_frame", 32'(frame),       32'h3);
      chk("t3_bp_sel",   32'(sel),         32'd3);
    end
    start       = 1'b0;
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("t3_hs_valid", 32'(frame_valid), 32'd0);
    chk("t3_hs_busy",  32'(busy),        32'd0);
    repeat (3) tick();
    chk("t3_idle_busy",  32'(busy),        32'd0);
    chk("t3_idle_valid", 32'(frame_valid), 32'd0);

    // 4: continuous mode, ready held high
    in_vec      = 4'b1010;
    cont        = 1'b1;
    frame_ready = 1'b1;
    start       = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    chk("t4_f1_valid", 32'(frame_valid), 32'd1);
    chk("t4_f1_frame", 32'(frame),       32'hA);
    chk("t4_f1_sel",   32'(sel),         32'd3);
    tick();
    chk("t4_hs_valid", 32'(frame_valid), 32'd0);
    chk("t4_hs_sel",   32'(sel),         32'd0);
    chk("t4_hs_busy",  32'(busy),        32'd1);
    cont   = 1'b0;
    in_vec = 4'b0110;
    repeat (15) tick();
    chk("t4_f2_early", 32'(frame_valid), 32'd0);
    tick();
    chk("t4_f2_valid", 32'(frame_valid), 32'd1);
    chk("t4_f2_frame", 32'(frame),       32'h6);
    tick();
    frame_ready = 1'b0;
    chk("t4_end_busy",  32'(busy),        32'd0);
    chk("t4_end_valid", 32'(frame_valid), 32'd0);
    chk("t4_end_sel",   32'(sel),         32'd0);

    // 5: start with no channels enabled is ignored
    ch_en = 4'b0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("t5_busy",  32'(busy),        32'd0);
      chk("t5_valid", 32'(frame_valid), 32'd0);
      tick();
    end

    // 6: reset mid-scan aborts, then a fresh scan works
    in_vec = 4'b1010;
    ch_en  = 4'b1111;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("t6_pre_sel", 32'(sel), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_sel",   32'(sel),         32'd0);
    chk("t6_rst_busy",  32'(busy),        32'd0);
    chk("t6_rst_valid", 32'(frame_valid), 32'd0);
    chk("t6_rst_frame", 32'(frame),       32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    chk("t6_valid", 32'(frame_valid), 32'd1);
    chk("t6_frame", 32'(frame),       32'hA);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("t6_hs_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
